// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit that sits beside the execute-stage ALU.
// One operation is accepted through a valid/ready handshake. It is computed
// over exactly 32 cycles, using shift-add for multiplies and restoring division
// for divides. The 32-bit result is then held until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operation presented on opA/opB/func
//   in_ready   unit can accept (IDLE only)
//   opA, opB   rs1 / rs2 operands
//   func       funct3 selecting MUL..REMU
//   out_valid  result valid (DONE)
//   out_ready  consumer takes result
//   out        result, held from fix-up until the next fix-up
//   busy       high while in CALC or DONE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [2:0]      func,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  state_t            state, state_next;
  logic [4:0]        cnt;
  logic [2:0]        func_q;
  logic              sign_a, sign_b;
  logic              b_zero, div_ovf;
  logic [XLEN-1:0]   a_orig;
  logic [XLEN-1:0]   b_mag;
  // hi is the upper product half (multiply) or the partial remainder (divide);
  // q is the multiplier shifting out (multiply) or dividend/quotient (divide).
  logic [XLEN-1:0]   hi, q;

  logic              a_signed, b_signed;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   step_hi, step_q;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, leave CALC after count 31, release on out_ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (cnt == 5'd31) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand conditioning at capture. Signed operands become magnitudes and
  // their signs are recorded for the fix-up stage.
  always_comb begin
    a_signed = (func == F_MULH) || (func == F_MULHSU) || (func == F_DIV) || (func == F_REM);
    b_signed = (func == F_MULH) || (func == F_DIV) || (func == F_REM);
    a_mag_in = (a_signed && opA[XLEN-1]) ? (~opA + 1'b1) : opA;
    b_mag_in = (b_signed && opB[XLEN-1]) ? (~opB + 1'b1) : opB;
  end

  // One iteration step. A multiply adds b to hi when the current multiplier bit
  // is set, then shifts {hi,q} right. A divide shifts the next dividend bit into
  // the remainder and subtracts b when it fits. The true difference is always
  // below b, so a 32-bit wrapped subtraction gives the exact remainder.
  always_comb begin
    mul_sum  = {1'b0, hi} + (q[0] ? {1'b0, b_mag} : '0);
    div_ge   = ({hi, q[XLEN-1]} >= {1'b0, b_mag});
    div_diff = {hi[XLEN-2:0], q[XLEN-1]} - b_mag;
    step_hi  = hi;
    step_q   = q;
    if (!func_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_q  = {mul_sum[0], q[XLEN-1:1]};
    end else if (div_ge) begin
      step_hi = div_diff;
      step_q  = {q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = {hi[XLEN-2:0], q[XLEN-1]};
      step_q  = {q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and special cases, applied to the result of the final step.
  always_comb begin
    prod     = {step_hi, step_q};
    prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    quot_fix = (sign_a ^ sign_b) ? (~step_q + 1'b1) : step_q;
    rem_fix  = sign_a ? (~step_hi + 1'b1) : step_hi;
    result   = '0;
    case (func_q)
      F_MUL:                     result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      F_DIV:  result = b_zero ? '1 : (div_ovf ? {1'b1, {(XLEN-1){1'b0}}} : quot_fix);
      F_DIVU: result = b_zero ? '1 : step_q;
      F_REM:  result = b_zero ? a_orig : (div_ovf ? '0 : rem_fix);
      F_REMU: result = b_zero ? a_orig : step_hi;
      default: result = '0;
    endcase
  end

  // Datapath registers. Operands are captured on accept, iterated in CALC,
  // and out is loaded on the last CALC edge and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      func_q  <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
      div_ovf <= 1'b0;
      a_orig  <= '0;
      b_mag   <= '0;
      hi      <= '0;
      q       <= '0;
      out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt     <= '0;
            func_q  <= func;
            sign_a  <= a_signed && opA[XLEN-1];
            sign_b  <= b_signed && opB[XLEN-1];
            b_zero  <= (opB == '0);
            div_ovf <= (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
            a_orig  <= opA;
            b_mag   <= b_mag_in;
            hi      <= '0;
            q       <= a_mag_in;
          end
        end
        CALC: begin
          hi  <= step_hi;
          q   <= step_q;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) out <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit. Expected results are pushed to a scoreboard
// queue when an operation is driven and popped when the unit presents out.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [2:0]  func = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;

  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .func(func),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation and push its expected result. Returns #1 after the accept edge.
  task automatic applyStimulus(input string tag, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
    @(negedge clk);
    compare({tag, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
    func = f; opA = a; opB = b; in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    opA = $urandom; opB = $urandom; func = 3'($urandom_range(0, 7));
    compare({tag, " in_ready after accept"}, {31'b0, in_ready}, 32'd0);
    compare({tag, " busy after accept"}, {31'b0, busy}, 32'd1);
  endtask

  // Count edges from accept (edge 1) until out_valid, bounded.
  task automatic waitResult(input string tag);
    int lat = 1;
    bit rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    compare({tag, " latency"}, 32'(lat), 32'd33);
    compare({tag, " in_ready low in CALC"}, {31'b0, rdy_seen}, 32'd0);
    compare({tag, " in_ready low in DONE"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=0x%08h", tag, out);
    end else begin
      exp = sb.pop_front();
      compare({tag, " result"}, out, exp);
    end
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    compare({tag, " out_valid after release"}, {31'b0, out_valid}, 32'd0);
    compare({tag, " in_ready after release"}, {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    applyStimulus(tag, f, a, b, exp);
    waitResult(tag);
    checkOutput(tag);
    releaseResult(tag);
  endtask

  initial begin
    // Reset values while reset is held.
    #2;
    compare("reset in_ready", {31'b0, in_ready}, 32'd1);
    compare("reset out_valid", {31'b0, out_valid}, 32'd0);
    compare("reset busy", {31'b0, busy}, 32'd0);
    compare("reset out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp("MUL 8x3",        3'b000, 32'd8,        32'd3,        32'h0000_0018);
    runOp("MULH -1x-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp("MULHU max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("MULHSU -1x2",    3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);
    runOp("DIV -20/3",      3'b100, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA);
    runOp("REM -20/3",      3'b110, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE);
    runOp("DIVU 20/3",      3'b101, 32'd20,       32'd3,        32'd6);
    runOp("REMU 20/3",      3'b111, 32'd20,       32'd3,        32'd2);
    runOp("DIV 7/0",        3'b100, 32'd7,        32'd0,        32'hFFFF_FFFF);
    runOp("REMU 7/0",       3'b111, 32'd7,        32'd0,        32'd7);
    runOp("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp("MUL -7x5",       3'b000, 32'hFFFF_FFF9, 32'd5,        32'hFFFF_FFDD);

    // Backpressure: hold DONE for 10 cycles while the inputs churn.
    applyStimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
    waitResult("DIVU 100/7");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2) == 1;
      opA = $urandom; opB = $urandom;
      @(posedge clk); #1;
      compare("hold out_valid", {31'b0, out_valid}, 32'd1);
      compare("hold out", out, 32'd14);
    end
    checkOutput("DIVU 100/7");

    // Release with a queued op already presented: accepted on the next edge.
    @(negedge clk);
    func = 3'b000; opA = 32'd8; opB = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(32'h0000_0018);
    @(posedge clk); #1;
    compare("queued release out_valid", {31'b0, out_valid}, 32'd0);
    compare("queued release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    compare("queued accept in_ready", {31'b0, in_ready}, 32'd0);
    compare("queued accept busy", {31'b0, busy}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    waitResult("queued MUL");
    checkOutput("queued MUL");
    releaseResult("queued MUL");

    // Reset in the middle of CALC at counter 15.
    applyStimulus("abort MUL", 3'b000, 32'd5, 32'd5, 32'd25);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    compare("abort in_ready", {31'b0, in_ready}, 32'd1);
    compare("abort out_valid", {31'b0, out_valid}, 32'd0);
    compare("abort busy", {31'b0, busy}, 32'd0);
    compare("abort out", out, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    runOp("MULHU 2^16x2^16", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit alongside the ExecutionUnit in the execute stage. When decode sees auxFunc = 7'b0000001, it routes opA, opB and func here instead of the single-cycle ALU. The unit accepts one operation through a valid/ready handshake and computes it over a fixed 32-cycle shift-add or restoring-divide sequence. It holds the 32-bit result until the writeback side takes it.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented on opA/opB/func
- in_ready  out  1  unit can accept; high only in IDLE
- opA  in  32  rs1 operand
- opB  in  32  rs2 operand
- func  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out  out  32  result
- busy  out  1  high in CALC or DONE

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch func, capture operands, clear the counter and go to CALC.
  - CALC: runs for exactly 32 cycles, processing one bit per cycle. Counter runs 0..31. On count 31, apply sign fix-up and special cases, register out and go to DONE.
  - DONE: out_valid=1. If out_ready is high, go to IDLE. Otherwise hold.
- Operand capture, signed treatment:
  - opA is signed for MULH, MULHSU, DIV and REM.
  - opB is signed for MULH, DIV and REM.
  - Signed operands are converted to magnitude, and their sign bits are recorded.
- Multiply:
  - Unsigned 32x32 shift-add into a 64-bit accumulator.
  - The product is negated if the recorded signs differ.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
  - MUL low bits are identical for any sign treatment.
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved at fix-up and still taking full latency:
  - opB=0: DIV/DIVU return 0xFFFFFFFF. REM/REMU return opA unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000. REM of the same operands returns 0.
- out holds its value from entry to DONE until the next fix-up. opA/opB/func are ignored outside IDLE.
- No exceptions and no flags are raised.

## Timing
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, counter=0, datapath registers 0.
- Accept occurs on the rising edge where in_valid && in_ready. in_ready drops after that edge.
- Latency: out_valid rises after the 33rd rising edge following the accept edge (1 capture edge, then 32 CALC edges). Latency is the same for every func and every operand value.
- Release: the DONE→IDLE transition happens on the edge where out_valid && out_ready.
  - out_valid falls and in_ready rises after that edge.
  - A new accept is possible on the following edge, so back-to-back throughput is one op per 34 cycles with out_ready held high.
- out_ready has no effect outside DONE. It may be held high permanently.
- If in_valid is high in DONE, nothing is accepted; the op waits for IDLE.
- Reset asserted mid-CALC or mid-DONE aborts immediately. The pending result is lost and out_valid=0 with no glitch to 1.
- in_valid is high-level sampled, with no combinational in→out paths. in_ready and out_valid are register-driven.

## Test plan
- MUL 8×3 → out=24 (0x00000018), 33 edges after accept. in_ready=0 throughout CALC/DONE.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU on the same operands → 0xFFFFFFFE. MULHSU with opA=0xFFFFFFFF, opB=2 → 0xFFFFFFFF.
- Division signs:
  - DIV -20/3 → 0xFFFFFFFA (-6). REM -20/3 → 0xFFFFFFFE (-2).
  - DIVU 20/3 → 6. REMU 20/3 → 2.
- Divide-by-zero and overflow:
  - DIV 7/0 → 0xFFFFFFFF. REMU 7/0 → 7.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
  - All of these take the same 33-edge latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling opA/opB/in_valid. out and out_valid must stay stable. Raising out_ready then releases, and a queued in_valid is accepted on the next edge.
- Reset in CALC at counter=15: outputs go to reset values asynchronously. A subsequent MULHU 0x10000×0x10000 → 0x00000001 is correct.
